// File: rtl/preg_freelist.sv
// rtl/preg_freelist.sv - physical register free list with speculative and committed allocation heads
// Dual-lane pop at rename, dual-lane push at commit, flush rolls spec_head back to cmt_head.
module preg_freelist #(
  parameter int NUM_PREGS = 64,
  parameter int NUM_AREGS = 32,
  parameter int PW        = $clog2(NUM_PREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    alloc_req,
  output logic          alloc_ready,
  output logic [PW-1:0] alloc_preg0,
  output logic [PW-1:0] alloc_preg1,
  input  logic [1:0]    free_valid,
  input  logic [PW-1:0] free_preg0,
  input  logic [PW-1:0] free_preg1,
  input  logic [1:0]    commit_alloc,
  input  logic          flush,
  output logic [PW:0]   num_free
);

  localparam logic [PW:0]   INIT_FREE = (PW+1)'(NUM_PREGS - NUM_AREGS);
  localparam logic [PW-1:0] INIT_TAIL = PW'(NUM_PREGS - NUM_AREGS);

  logic [PW-1:0] entries [NUM_PREGS];
  logic [PW-1:0] spec_head;
  logic [PW-1:0] cmt_head;
  logic [PW-1:0] tail;
  logic [PW:0]   spec_cnt;
  logic [PW:0]   cmt_cnt;

  logic [1:0]    nalloc;
  logic [1:0]    nfree;
  logic [1:0]    ncmt;
  logic [PW-1:0] spec_head_p1;
  logic [PW-1:0] tail_lane1;

  // The last single free entry is withheld so a two-lane grant never needs a partial answer.
  assign alloc_ready  = (spec_cnt >= (PW+1)'(2)) && !flush;
  assign spec_head_p1 = spec_head + PW'(1);
  assign alloc_preg0  = entries[spec_head];
  assign alloc_preg1  = entries[spec_head_p1];
  assign num_free     = spec_cnt;

  assign nalloc = alloc_ready ? ({1'b0, alloc_req[0]} + {1'b0, alloc_req[1]}) : 2'd0;
  assign nfree  = {1'b0, free_valid[0]} + {1'b0, free_valid[1]};
  assign ncmt   = {1'b0, commit_alloc[0]} + {1'b0, commit_alloc[1]};

  // Lane 1 lands right after lane 0 only when lane 0 is also writing.
  assign tail_lane1 = tail + PW'(free_valid[0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_PREGS; k++) begin
        entries[k] <= (k < NUM_PREGS - NUM_AREGS) ? PW'(NUM_AREGS + k) : '0;
      end
      spec_head <= '0;
      cmt_head  <= '0;
      tail      <= INIT_TAIL;
      spec_cnt  <= INIT_FREE;
      cmt_cnt   <= INIT_FREE;
    end else begin
      if (free_valid[0]) entries[tail] <= free_preg0;
      if (free_valid[1]) entries[tail_lane1] <= free_preg1;
      tail     <= tail + PW'(nfree);
      cmt_head <= cmt_head + PW'(ncmt);
      cmt_cnt  <= cmt_cnt + (PW+1)'(nfree) - (PW+1)'(ncmt);
      if (flush) begin
        spec_head <= cmt_head + PW'(ncmt);
        spec_cnt  <= cmt_cnt + (PW+1)'(nfree) - (PW+1)'(ncmt);
      end else begin
        spec_head <= spec_head + PW'(nalloc);
        spec_cnt  <= spec_cnt + (PW+1)'(nfree) - (PW+1)'(nalloc);
      end
    end
  end

  // Caller protocol checks; behaviour after any of these fire is undefined.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (cmt_cnt >= spec_cnt);
      assert (cmt_cnt <= INIT_FREE);
      assert ((PW+1)'(ncmt) <= cmt_cnt - spec_cnt);
    end
  end

endmodule

// File: tb/tb_preg_freelist.sv
// tb/tb_preg_freelist.sv - scoreboard bench for preg_freelist
// Stimulus pushes expected grants into exp_q; the negedge monitor pops and compares.
module tb_preg_freelist;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    alloc_req;
  logic          alloc_ready;
  logic [PW-1:0] alloc_preg0;
  logic [PW-1:0] alloc_preg1;
  logic [1:0]    free_valid;
  logic [PW-1:0] free_preg0;
  logic [PW-1:0] free_preg1;
  logic [1:0]    commit_alloc;
  logic          flush;
  logic [PW:0]   num_free;

  int checks = 0;
  int failures = 0;

  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] fl[$];
  logic [PW-1:0] unc[$];
  logic [PW-1:0] comm[$];
  int            grant_cnt[NP];
  int            rel_cnt[NP];

  preg_freelist #(.NUM_PREGS(NP), .NUM_AREGS(NA), .PW(PW)) dut (
    .clk(clk),
    .reset(reset),
    .alloc_req(alloc_req),
    .alloc_ready(alloc_ready),
    .alloc_preg0(alloc_preg0),
    .alloc_preg1(alloc_preg1),
    .free_valid(free_valid),
    .free_preg0(free_preg0),
    .free_preg1(free_preg1),
    .commit_alloc(commit_alloc),
    .flush(flush),
    .num_free(num_free)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_grant(input int lane, input logic [PW-1:0] p);
    logic [PW-1:0] e;
    int outstanding;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL grant_lane%0d: got preg %0d, expected no grant", lane, p);
    end else begin
      e = exp_q.pop_front();
      if (p !== e) begin
        failures++;
        $display("FAIL grant_lane%0d: got preg %0d, expected %0d", lane, p, e);
      end
    end
    outstanding = ((int'(p) < NA) ? 1 : 0) + grant_cnt[p] - rel_cnt[p];
    checks++;
    if (outstanding != 0) begin
      failures++;
      $display("FAIL dup_grant: preg %0d outstanding count %0d, expected 0", p, outstanding);
    end
    grant_cnt[p]++;
  endtask

  always @(negedge clk) begin
    if (!reset && alloc_ready) begin
      if (alloc_req[0]) check_grant(0, alloc_preg0);
      if (alloc_req[1]) check_grant(1, alloc_preg1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    alloc_req    = 2'b00;
    free_valid   = 2'b00;
    free_preg0   = '0;
    free_preg1   = '0;
    commit_alloc = 2'b00;
    flush        = 1'b0;
  endtask

  function automatic int min2(input int a);
    return (a < 2) ? a : 2;
  endfunction

  // One model-driven cycle: frees come from the oldest committed pregs, commits retire the oldest
  // uncommitted allocations, grants come from the model list before this cycle's frees land.
  task automatic drive_cycle(input logic [1:0] req, input int nf, input int nc);
    logic [PW-1:0] f[$];
    logic [PW-1:0] g;
    bit rdy;
    rdy = (fl.size() >= 2);
    alloc_req = req;
    flush = 1'b0;
    free_valid = 2'b00;
    free_preg0 = '0;
    free_preg1 = '0;
    for (int i = 0; i < nf; i++) f.push_back(comm.pop_front());
    if (nf == 2) begin
      free_valid = 2'b11; free_preg0 = f[0]; free_preg1 = f[1];
    end else if (nf == 1) begin
      if ($urandom_range(0, 1) == 1) begin
        free_valid = 2'b10; free_preg1 = f[0];
      end else begin
        free_valid = 2'b01; free_preg0 = f[0];
      end
    end
    foreach (f[i]) rel_cnt[f[i]]++;
    commit_alloc = (nc == 2) ? 2'b11 : (nc == 1) ? (($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01) : 2'b00;
    for (int i = 0; i < nc; i++) comm.push_back(unc.pop_front());
    #1;
    chk("model_ready", int'(alloc_ready), int'(rdy));
    chk("model_num_free", int'(num_free), fl.size());
    if (rdy) begin
      for (int l = 0; l < 2; l++) begin
        if (req[l]) begin
          g = fl.pop_front();
          exp_q.push_back(g);
          unc.push_back(g);
        end
      end
    end
    foreach (f[i]) fl.push_back(f[i]);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time exceeded, expected completion");
    $fatal(1);
  end

  initial begin
    logic [PW-1:0] c;
    int r;
    logic [1:0] rq;

    idle_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("reset_num_free", int'(num_free), 32);
    chk("reset_ready", int'(alloc_ready), 1);
    chk("reset_preg0", int'(alloc_preg0), 32);
    chk("reset_preg1", int'(alloc_preg1), 33);

    for (int i = 0; i < 16; i++) begin
      alloc_req = 2'b11;
      exp_q.push_back(PW'(32 + 2*i));
      exp_q.push_back(PW'(33 + 2*i));
      tick();
    end
    #1;
    chk("empty_ready", int'(alloc_ready), 0);
    chk("empty_num_free", int'(num_free), 0);
    alloc_req = 2'b00;
    tick();

    for (int i = 0; i < 16; i++) begin
      commit_alloc = 2'b11;
      tick();
    end
    commit_alloc = 2'b00;

    // Freed pregs must not be granted in the cycle they arrive.
    free_valid = 2'b11; free_preg0 = 6'd5; free_preg1 = 6'd9;
    alloc_req = 2'b11;
    rel_cnt[5]++; rel_cnt[9]++;
    #1;
    chk("no_bypass_ready", int'(alloc_ready), 0);
    tick();
    free_valid = 2'b00;
    #1;
    chk("after_free_ready", int'(alloc_ready), 1);
    chk("after_free_preg0", int'(alloc_preg0), 5);
    chk("after_free_preg1", int'(alloc_preg1), 9);
    chk("after_free_num_free", int'(num_free), 2);
    exp_q.push_back(6'd5);
    exp_q.push_back(6'd9);
    tick();
    alloc_req = 2'b00;
    commit_alloc = 2'b11;
    tick();
    commit_alloc = 2'b00;

    for (int i = 0; i < 16; i++) begin
      free_valid = 2'b11;
      free_preg0 = PW'(32 + 2*i);
      free_preg1 = PW'(33 + 2*i);
      rel_cnt[32 + 2*i]++;
      rel_cnt[33 + 2*i]++;
      tick();
    end
    free_valid = 2'b00;
    #1;
    chk("refill_num_free", int'(num_free), 32);

    for (int i = 0; i < 3; i++) begin
      alloc_req = 2'b11;
      exp_q.push_back(PW'(32 + 2*i));
      exp_q.push_back(PW'(33 + 2*i));
      tick();
    end
    alloc_req = 2'b00;
    flush = 1'b1;
    commit_alloc = 2'b01;
    #1;
    chk("flush_ready", int'(alloc_ready), 0);
    tick();
    flush = 1'b0;
    commit_alloc = 2'b00;
    for (int p = 33; p <= 37; p++) rel_cnt[p]++;
    #1;
    chk("rollback_preg0", int'(alloc_preg0), 33);
    chk("rollback_num_free", int'(num_free), 31);
    chk("rollback_ready", int'(alloc_ready), 1);

    for (int p = 33; p < 64; p++) fl.push_back(PW'(p));
    comm.push_back(6'd32);
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 2);
      rq = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
      drive_cycle(rq, $urandom_range(0, min2(comm.size())), $urandom_range(0, min2(unc.size())));
    end
    for (int i = 0; i < 100 && (unc.size() != 0 || comm.size() != 0); i++) begin
      drive_cycle(2'b00, min2(comm.size()), min2(unc.size()));
    end
    #1;
    chk("final_num_free", int'(num_free), 32);

    // Two committed, one rolled back, two identity pregs returned, all in the flush cycle.
    drive_cycle(2'b11, 0, 0);
    drive_cycle(2'b01, 0, 0);
    c = unc[2];
    alloc_req = 2'b11;
    flush = 1'b1;
    commit_alloc = 2'b11;
    free_valid = 2'b11; free_preg0 = 6'd0; free_preg1 = 6'd1;
    rel_cnt[0]++; rel_cnt[1]++; rel_cnt[c]++;
    #1;
    chk("combo_ready", int'(alloc_ready), 0);
    chk("combo_num_free_before", int'(num_free), 29);
    tick();
    idle_in();
    void'(unc.pop_front());
    void'(unc.pop_front());
    void'(unc.pop_front());
    fl.push_front(c);
    fl.push_back(6'd0);
    fl.push_back(6'd1);
    #1;
    chk("combo_num_free_after", int'(num_free), 32);
    chk("combo_preg0_rolled_back", int'(alloc_preg0), int'(c));
    chk("combo_preg1", int'(alloc_preg1), int'(fl[1]));

    drive_cycle(2'b11, 0, 0);
    reset = 1'b1;
    alloc_req = 2'b11;
    free_valid = 2'b11; free_preg0 = 6'd2; free_preg1 = 6'd3;
    commit_alloc = 2'b11;
    tick();
    reset = 1'b0;
    idle_in();
    for (int p = 0; p < NP; p++) rel_cnt[p] = grant_cnt[p];
    #1;
    chk("midreset_num_free", int'(num_free), 32);
    chk("midreset_ready", int'(alloc_ready), 1);
    chk("midreset_preg0", int'(alloc_preg0), 32);
    chk("midreset_preg1", int'(alloc_preg1), 33);
    tick();

    chk("pending_grants", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/preg_freelist.md
# preg_freelist

Physical-register free list for the rename/commit path. Rename pops up to two free physical registers per cycle for destination writes. Commit pushes back up to two superseded physical registers per cycle and advances a committed-allocation pointer. On a pipeline flush the speculative allocation pointer rolls back to the committed one, so every register handed out after the last commit is reclaimed.

## Interface
- NUM_PREGS, 64: physical registers; power of two.
- NUM_AREGS, 32: architectural registers; pregs 0..NUM_AREGS-1 are the reset-time identity mapping.
- PW, $clog2(NUM_PREGS): preg index width.
- clk  in  1  clock, all state on posedge.
- reset  in  1  synchronous, active-high.
- alloc_req  in  2  bit i requests one preg. Legal values: 00, 01, 11.
- alloc_ready  out  1  list can grant two pregs this cycle.
- alloc_preg0 / alloc_preg1  out  PW each  pregs granted to request lanes 0 / 1.
- free_valid  in  2  lane i returns free_preg_i.
- free_preg0 / free_preg1  in  PW each  returned pregs.
- commit_alloc  in  2  bit i: committing instruction i had allocated a preg. Any pattern is legal; only the popcount matters.
- flush  in  1  discard all uncommitted allocations.
- num_free  out  PW+1  speculative free count.

## Operation
- Storage: circular buffer of NUM_PREGS entries, each PW bits.
- Pointers, each PW bits and wrapping modulo NUM_PREGS:
  - spec_head: next preg to allocate.
  - cmt_head: allocation point as of the last commit.
  - tail: next slot to write.
- Counters, each PW+1 bits:
  - spec_cnt = free entries from spec_head.
  - cmt_cnt = free entries from cmt_head.
- Reset:
  - entry[k] = NUM_AREGS+k for k < NUM_PREGS-NUM_AREGS.
  - spec_head = cmt_head = 0; tail = NUM_PREGS-NUM_AREGS.
  - spec_cnt = cmt_cnt = NUM_PREGS-NUM_AREGS.
- alloc_ready = (spec_cnt >= 2) && !flush.
- alloc_preg0 = entry[spec_head]; alloc_preg1 = entry[spec_head+1]. Both are combinational from registers and valid only when alloc_ready is high.
- Grant: when alloc_ready is high, nalloc = popcount(alloc_req) and spec_head advances by nalloc. When alloc_ready is low, nalloc = 0.
- Free:
  - Valid lanes are compacted in lane order: lane 0 writes entry[tail], the next valid lane writes the following slot.
  - tail advances by nfree = popcount(free_valid).
  - Freed entries are allocatable from the next cycle only; no same-cycle bypass.
- Commit: cmt_head advances by ncmt = popcount(commit_alloc).
- Counter update each cycle:
  - cmt_cnt <= cmt_cnt + nfree - ncmt.
  - Without flush: spec_cnt <= spec_cnt + nfree - nalloc.
  - With flush: spec_head <= cmt_head + ncmt, and spec_cnt <= cmt_cnt + nfree - ncmt. Frees and commits in the flush cycle still apply; allocation does not.
- Invariants, checked by the bench and by simulation assertions:
  - cmt_cnt >= spec_cnt.
  - cmt_cnt <= NUM_PREGS-NUM_AREGS, so the buffer never overflows.
  - ncmt <= number of outstanding speculative allocations.
  - Any violation is a caller protocol error; RTL behaviour under violation is undefined.

## Timing
- Allocation is zero-latency: grant and preg values appear in the request cycle, and state updates at the next posedge.
- A freed preg is allocatable one cycle after it is freed, and never in the cycle it is freed.
- num_free reflects spec_cnt after the previous edge. Reset value: NUM_PREGS-NUM_AREGS (32 with defaults).
- Flush takes effect at the next edge. alloc_ready is low during the flush cycle and high the cycle after, provided spec_cnt >= 2.
- Reset asserted mid-operation overrides alloc, free, commit and flush in that cycle. The next cycle shows reset values.
- alloc_ready is low when spec_cnt is 0 or 1. The last single entry is not granted, even to a single-lane request.

## Test plan
- Reset, then idle:
  - num_free = 32, alloc_ready = 1.
  - alloc_preg0/1 = 32/33.
- alloc_req = 11 for 16 cycles:
  - Grants 32..63 in order.
  - Cycle 17: alloc_ready = 0, num_free = 0.
- Drain, then free 5 and 9 on lanes 0 and 1:
  - Next cycle alloc_ready = 1, alloc_preg0/1 = 5/9, num_free = 2.
  - Same-cycle alloc_req is not granted.
- Flush rollback:
  - Allocate 32..37 with no commits, then flush with commit_alloc = 01.
  - Next cycle alloc_preg0 = 33, num_free = 31.
- Wrap-around:
  - Run 200 cycles of random alloc, then free of the oldest allocated pregs, then commit.
  - Grants must follow free order exactly across pointer wrap.
  - No preg is outstanding twice; final num_free = 32 after all are returned.
- Simultaneous free + commit + flush + alloc_req = 11 in one cycle:
  - Alloc ignored; freed entries counted.
  - spec_head = cmt_head after the edge; reset mid-sequence restores 32/33.
